// File: rtl/alu_operand_sel.sv
// N-way EX-stage operand selector with a registered output, stall/flush control,
// and a saturating counter of live instructions that carried an out-of-range select.
module alu_operand_sel #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned SELW  = 2,
  parameter int unsigned CNTW  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSRC*WIDTH-1:0]   src_flat,
  input  logic [SELW-1:0]         sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        operand_q,
  output logic                    out_valid,
  output logic                    sel_err,
  output logic [CNTW-1:0]         err_cnt
);

  logic [31:0]       sel_ext;
  logic [WIDTH-1:0]  mux_d;
  logic              bad_d;

  logic              out_valid_q, out_valid_d;
  logic              sel_err_q, sel_err_d;
  logic [CNTW-1:0]   err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]  operand_d;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] cnt);
    if (cnt == {CNTW{1'b1}}) return cnt;
    return cnt + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  assign sel_ext = 32'(sel);
  assign bad_d   = (sel_ext >= NSRC);

  always_comb begin
    mux_d = '0;
    for (int k = 0; k < int'(NSRC); k++) begin
      if (sel_ext == 32'(k)) mux_d = src_flat[k*WIDTH +: WIDTH];
    end
  end

  // Next-state: flush beats stall beats load
  always_comb begin
    operand_d   = operand_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    err_cnt_d   = err_cnt_q;
    if (flush) begin
      operand_d   = '0;
      out_valid_d = 1'b0;
      sel_err_d   = 1'b0;
    end else if (!stall) begin
      operand_d   = mux_d;
      out_valid_d = in_valid;
      sel_err_d   = in_valid & bad_d;
      if (in_valid & bad_d) err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // EX-stage operand register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand_q   <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      operand_q   <= operand_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_operand_sel.sv
// Bench for alu_operand_sel: a 4-source/8-bit-counter instance and a
// 3-source/2-bit-counter instance driven from the same stimulus.
module tb_alu_operand_sel;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ch [4];
  logic [127:0] src_flat;
  logic [1:0]  sel;
  logic        in_valid, stall, flush;

  logic [31:0] a_op, b_op;
  logic        a_v, b_v, a_e, b_e;
  logic [7:0]  a_cnt;
  logic [1:0]  b_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_op  [2];
  logic        m_v   [2];
  logic        m_e   [2];
  int          m_cnt [2];
  int          ns    [2] = '{4, 3};
  int          cmax  [2] = '{255, 3};

  always #5 clk = ~clk;

  assign src_flat = {ch[3], ch[2], ch[1], ch[0]};

  alu_operand_sel #(.WIDTH(32), .NSRC(4), .SELW(2), .CNTW(8)) u_a (
    .clk(clk), .reset(reset), .src_flat(src_flat), .sel(sel),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .operand_q(a_op), .out_valid(a_v), .sel_err(a_e), .err_cnt(a_cnt)
  );

  alu_operand_sel #(.WIDTH(32), .NSRC(3), .SELW(2), .CNTW(2)) u_b (
    .clk(clk), .reset(reset), .src_flat(src_flat[95:0]), .sel(sel),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .operand_q(b_op), .out_valid(b_v), .sel_err(b_e), .err_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " a.operand"}, 64'(a_op),  64'(m_op[0]));
    chk({tag, " a.valid"},   64'(a_v),   64'(m_v[0]));
    chk({tag, " a.sel_err"}, 64'(a_e),   64'(m_e[0]));
    chk({tag, " a.err_cnt"}, 64'(a_cnt), 64'(m_cnt[0]));
    chk({tag, " b.operand"}, 64'(b_op),  64'(m_op[1]));
    chk({tag, " b.valid"},   64'(b_v),   64'(m_v[1]));
    chk({tag, " b.sel_err"}, 64'(b_e),   64'(m_e[1]));
    chk({tag, " b.err_cnt"}, 64'(b_cnt), 64'(m_cnt[1]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_op[i] = '0; m_v[i] = 1'b0; m_e[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  // Reference: what each instance should hold after the coming edge
  task automatic step(input string tag);
    for (int i = 0; i < 2; i++) begin
      if (flush) begin
        m_op[i] = '0; m_v[i] = 1'b0; m_e[i] = 1'b0;
      end else if (!stall) begin
        m_op[i] = (int'(sel) < ns[i]) ? ch[sel] : 32'd0;
        m_v[i]  = in_valid;
        m_e[i]  = in_valid && (int'(sel) >= ns[i]);
        if (m_e[i] && m_cnt[i] < cmax[i]) m_cnt[i]++;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [1:0] s, input logic v, input logic st, input logic fl);
    sel = s; in_valid = v; stall = st; flush = fl;
  endtask

  initial begin
    reset = 1'b1;
    ch = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    drive(2'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_all("power_on_reset");
    #1 reset = 1'b0;

    // Reset mid-cycle while holding 0xDEADBEEF
    ch[1] = 32'hDEADBEEF;
    drive(2'd1, 1'b1, 1'b0, 1'b0);
    step("load_deadbeef");
    #3 reset = 1'b1;
    model_reset();
    #1 check_all("async_reset");
    #1 reset = 1'b0;
    ch[1] = 32'h22222222;

    // Select sweep
    for (int s = 0; s < 4; s++) begin
      drive(2'(s), 1'b1, 1'b0, 1'b0);
      step($sformatf("sweep_sel%0d", s));
    end

    // Stall with changing inputs
    drive(2'd1, 1'b1, 1'b0, 1'b0);
    step("stall_load");
    for (int n = 0; n < 3; n++) begin
      drive(2'(n + 2), 1'b1, 1'b1, 1'b0);
      ch[0] = $urandom;
      step($sformatf("stall_hold%0d", n));
    end
    drive(2'd0, 1'b1, 1'b0, 1'b0);
    step("stall_release");

    // Flush beats stall
    drive(2'd2, 1'b1, 1'b1, 1'b1);
    step("flush_over_stall");

    // Out-of-range select on the 3-source instance
    drive(2'd3, 1'b1, 1'b0, 1'b0);
    step("err_valid");
    drive(2'd3, 1'b0, 1'b0, 1'b0);
    step("err_invalid");

    // Saturation of the 2-bit counter
    for (int n = 0; n < 5; n++) begin
      drive(2'd3, 1'b1, 1'b0, 1'b0);
      step($sformatf("sat%0d", n));
    end

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
      drive(2'($urandom_range(3, 0)), 1'($urandom),
            ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0));
      step($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
